// File: rtl/ex_if.sv
// ex_if: execute-stage bundle between decode/hazard logic and the ex_stage pipeline block.
interface ex_if #(parameter int XLEN = 32, parameter int REGW = 5);
    logic            FlushE, StallE;
    logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, InverseBrCondD;
    logic [1:0]      ResultSrcD;
    logic [3:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [REGW-1:0] Rs1D, Rs2D, RdD;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [XLEN-1:0] ALUResultM_fwd, ResultW;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic [REGW-1:0] Rs1E, Rs2E, RdE;
    logic            ResultSrcE0;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [REGW-1:0] RdM;
    modport slave (
        input  FlushE, StallE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, InverseBrCondD,
               ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               ForwardAE, ForwardBE, ALUResultM_fwd, ResultW,
        output PCSrcE, PCTargetE, Rs1E, Rs2E, RdE, ResultSrcE0, RegWriteM, MemWriteM,
               ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
    );
    modport master (
        output FlushE, StallE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, InverseBrCondD,
               ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               ForwardAE, ForwardBE, ALUResultM_fwd, ResultW,
        input  PCSrcE, PCTargetE, Rs1E, Rs2E, RdE, ResultSrcE0, RegWriteM, MemWriteM,
               ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with ID/EX and EX/MEM registers, forwarding, ALU and branch resolve.
// ALU codes: ADD 0, SUB 1, AND 2, OR 3, LESS 5, SLL 6, SRL 7, SRA 8; anything else yields 0.
module ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic clk,
    input logic reset,
    ex_if.slave ex
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_LESS = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8;

    typedef struct packed {
        logic            reg_write, mem_write, jump, branch, alu_src, inv;
        logic [1:0]      result_src;
        logic [3:0]      alu_ctrl;
        logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
        logic [REGW-1:0] rs1, rs2, rd;
    } idex_t;

    typedef struct packed {
        logic            reg_write, mem_write;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_res, write_data, pc4;
        logic [REGW-1:0] rd;
    } exmem_t;

    idex_t           d, e;
    exmem_t          m;
    logic [XLEN-1:0] src_a, write_data, src_b, alu;

    assign d = '{ex.RegWriteD, ex.MemWriteD, ex.JumpD, ex.BranchD, ex.ALUSrcD, ex.InverseBrCondD,
                 ex.ResultSrcD, ex.ALUControlD, ex.RD1D, ex.RD2D, ex.ImmExtD, ex.PCD, ex.PCPlus4D,
                 ex.Rs1D, ex.Rs2D, ex.RdD};

    // Flush outranks stall so a squashed instruction can never be held in E.
    always_ff @(posedge clk or posedge reset)
        if (reset) e <= '0;
        else if (ex.FlushE) e <= '0;
        else if (!ex.StallE) e <= d;

    assign src_a      = ex.ForwardAE == 2'b01 ? ex.ResultW :
                        ex.ForwardAE == 2'b10 ? ex.ALUResultM_fwd : e.rd1;
    assign write_data = ex.ForwardBE == 2'b01 ? ex.ResultW :
                        ex.ForwardBE == 2'b10 ? ex.ALUResultM_fwd : e.rd2;
    assign src_b      = e.alu_src ? e.imm : write_data;

    always_comb begin
        alu = '0;
        case (e.alu_ctrl)
            ALU_ADD:  alu = src_a + src_b;
            ALU_SUB:  alu = src_a - src_b;
            ALU_AND:  alu = src_a & src_b;
            ALU_OR:   alu = src_a | src_b;
            ALU_LESS: alu = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLL:  alu = src_a << src_b[4:0];
            ALU_SRL:  alu = src_a >> src_b[4:0];
            ALU_SRA:  alu = $unsigned($signed(src_a) >>> src_b[4:0]);
            default:  alu = '0;
        endcase
    end

    assign ex.PCSrcE      = e.jump | (e.branch & ((alu == '0) ^ e.inv));
    assign ex.PCTargetE   = e.pc + e.imm;
    assign ex.Rs1E        = e.rs1;
    assign ex.Rs2E        = e.rs2;
    assign ex.RdE         = e.rd;
    assign ex.ResultSrcE0 = e.result_src[0];

    always_ff @(posedge clk or posedge reset)
        if (reset) m <= '0;
        else m <= '{e.reg_write, e.mem_write, e.result_src, alu, write_data, e.pc4, e.rd};

    assign ex.RegWriteM  = m.reg_write;
    assign ex.MemWriteM  = m.mem_write;
    assign ex.ResultSrcM = m.result_src;
    assign ex.ALUResultM = m.alu_res;
    assign ex.WriteDataM = m.write_data;
    assign ex.PCPlus4M   = m.pc4;
    assign ex.RdM        = m.rd;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table with an EX/MEM scoreboard queue, plus reset, stall, flush and async-reset sequences.
module tb_ex_stage;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                           LESS = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
        logic        src, inv, br, jmp, rw, mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
        logic [31:0] mf, w;
        logic [31:0] res, wd, tgt;
        logic        pcs;
    } vec_t;

    typedef struct {
        logic        rw, mw;
        logic [1:0]  rs;
        logic [31:0] res, wd, pc4;
        logic [4:0]  rd;
    } m_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[16];
    m_t   sb[$];
    m_t   got;

    ex_if #(.XLEN(32), .REGW(5)) bus ();
    ex_stage #(.XLEN(32), .REGW(5)) dut (.clk(clk), .reset(reset), .ex(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_d();
        {bus.FlushE, bus.StallE, bus.RegWriteD, bus.MemWriteD, bus.JumpD, bus.BranchD} = '0;
        {bus.ALUSrcD, bus.InverseBrCondD, bus.ResultSrcD, bus.ALUControlD} = '0;
        {bus.RD1D, bus.RD2D, bus.ImmExtD, bus.PCD, bus.PCPlus4D} = '0;
        {bus.Rs1D, bus.Rs2D, bus.RdD} = '0;
    endtask

    task automatic set_fwd(input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] mf, input logic [31:0] w);
        bus.ForwardAE = fa;
        bus.ForwardBE = fb;
        bus.ALUResultM_fwd = mf;
        bus.ResultW = w;
    endtask

    task automatic set_d(input vec_t v, input logic [31:0] pc4);
        bus.ALUControlD = v.op;
        bus.RD1D = v.a;
        bus.RD2D = v.b;
        bus.ImmExtD = v.imm;
        bus.PCD = v.pc;
        bus.PCPlus4D = pc4;
        bus.ALUSrcD = v.src;
        bus.InverseBrCondD = v.inv;
        bus.BranchD = v.br;
        bus.JumpD = v.jmp;
        bus.RegWriteD = v.rw;
        bus.MemWriteD = v.mw;
        bus.ResultSrcD = v.rs;
        bus.RdD = v.rd;
        bus.Rs1D = v.rd + 5'd1;
        bus.Rs2D = v.rd + 5'd2;
    endtask

    task automatic check_m(input string tag);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            check({tag, " ALUResultM"}, bus.ALUResultM, got.res);
            check({tag, " WriteDataM"}, bus.WriteDataM, got.wd);
            check({tag, " PCPlus4M"}, bus.PCPlus4M, got.pc4);
            check({tag, " RdM"}, 32'(bus.RdM), 32'(got.rd));
            check({tag, " RegWriteM"}, 32'(bus.RegWriteM), 32'(got.rw));
            check({tag, " MemWriteM"}, 32'(bus.MemWriteM), 32'(got.mw));
            check({tag, " ResultSrcM"}, 32'(bus.ResultSrcM), 32'(got.rs));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " PCSrcE"}, 32'(bus.PCSrcE), 0);
        check({tag, " PCTargetE"}, bus.PCTargetE, 0);
        check({tag, " RdE"}, 32'(bus.RdE), 0);
        check({tag, " ResultSrcE0"}, 32'(bus.ResultSrcE0), 0);
        check({tag, " RegWriteM"}, 32'(bus.RegWriteM), 0);
        check({tag, " MemWriteM"}, 32'(bus.MemWriteM), 0);
        check({tag, " ALUResultM"}, bus.ALUResultM, 0);
        check({tag, " WriteDataM"}, bus.WriteDataM, 0);
        check({tag, " RdM"}, 32'(bus.RdM), 0);
    endtask

    initial begin
        // op, a, b, imm, pc, src, inv, br, jmp, rw, mw, rs, rd, fa, fb, mf, w, res, wd, tgt, pcs
        vecs[0]  = '{ADD,  32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 5'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'd12, 32'd7, 32'd0, 1'b0};
        vecs[1]  = '{SUB,  32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd4, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
        vecs[2]  = '{SRA,  32'h80000000, 32'd31, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd5, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd31, 32'd0, 1'b0};
        vecs[3]  = '{SRL,  32'h80000000, 32'd31, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd6, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1, 32'd31, 32'd0, 1'b0};
        vecs[4]  = '{LESS, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd7, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 1'b0};
        vecs[5]  = '{LESS, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd8, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[6]  = '{SLL,  32'h40000001, 32'd33, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd9, 2'b00, 2'b00, 32'd0, 32'd0, 32'h80000002, 32'd33, 32'd0, 1'b0};
        vecs[7]  = '{ADD,  32'hDEAD, 32'hBEEF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 5'd10, 2'b10, 2'b01, 32'd100, 32'd4, 32'd104, 32'd4, 32'd0, 1'b0};
        vecs[8]  = '{ADD,  32'hDEAD, 32'hBEEF, 32'd8, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd11, 2'b10, 2'b01, 32'd100, 32'd4, 32'd108, 32'd4, 32'h18, 1'b0};
        vecs[9]  = '{SUB,  32'd9, 32'd9, 32'h20, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd9, 32'h120, 1'b1};
        vecs[10] = '{SUB,  32'd9, 32'd9, 32'h20, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd9, 32'h120, 1'b0};
        vecs[11] = '{SUB,  32'd9, 32'd8, 32'h20, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1, 32'd8, 32'h120, 1'b1};
        vecs[12] = '{ADD,  32'd1, 32'd2, 32'h40, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 5'd1, 2'b00, 2'b00, 32'd0, 32'd0, 32'd3, 32'd2, 32'h240, 1'b1};
        vecs[13] = '{AND_, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd12, 2'b11, 2'b11, 32'd77, 32'd55, 32'hF000, 32'hFF00, 32'd0, 1'b0};
        vecs[14] = '{OR_,  32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd13, 2'b00, 2'b10, 32'h000F, 32'd0, 32'hF0FF, 32'h000F, 32'd0, 1'b0};
        vecs[15] = '{4'hF, 32'd5, 32'd7, 32'hFFFFFFFC, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 5'd14, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd7, 32'd0, 1'b1};

        clr_d();
        set_fwd(2'b00, 2'b00, 32'd0, 32'd0);
        set_d(vecs[12], 32'h1234);
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            set_d(vecs[i], 32'h1000 + 32'(i) * 4);
            @(posedge clk);
            #1;
            if (sb.size() > 0) check_m($sformatf("v%0d", i - 1));
            set_fwd(vecs[i].fa, vecs[i].fb, vecs[i].mf, vecs[i].w);
            #1;
            check($sformatf("v%0d PCSrcE", i), 32'(bus.PCSrcE), 32'(vecs[i].pcs));
            check($sformatf("v%0d PCTargetE", i), bus.PCTargetE, vecs[i].tgt);
            check($sformatf("v%0d RdE", i), 32'(bus.RdE), 32'(vecs[i].rd));
            check($sformatf("v%0d Rs1E", i), 32'(bus.Rs1E), 32'(vecs[i].rd + 5'd1));
            check($sformatf("v%0d Rs2E", i), 32'(bus.Rs2E), 32'(vecs[i].rd + 5'd2));
            check($sformatf("v%0d ResultSrcE0", i), 32'(bus.ResultSrcE0), 32'(vecs[i].rs[0]));
            sb.push_back('{vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].res, vecs[i].wd, 32'h1000 + 32'(i) * 4, vecs[i].rd});
        end
        clr_d();
        @(posedge clk);
        #1 check_m("v15");
        set_fwd(2'b00, 2'b00, 32'd0, 32'd0);

        // Stall: a jump held in E for two cycles while D changes underneath.
        set_d(vecs[12], 32'h2000);
        bus.RdD = 5'd7;
        bus.PCD = 32'h300;
        bus.ImmExtD = 32'd4;
        @(posedge clk);
        #1 check("stall load RdE", 32'(bus.RdE), 7);
        check("stall load PCTargetE", bus.PCTargetE, 32'h304);
        bus.StallE = 1'b1;
        bus.RdD = 5'd9;
        bus.JumpD = 1'b0;
        bus.RD1D = 32'd50;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d RdE", c), 32'(bus.RdE), 7);
            check($sformatf("stall%0d PCSrcE", c), 32'(bus.PCSrcE), 1);
            check($sformatf("stall%0d RdM", c), 32'(bus.RdM), 7);
            check($sformatf("stall%0d ALUResultM", c), bus.ALUResultM, 3);
        end

        // Flush together with stall must bubble E.
        bus.FlushE = 1'b1;
        @(posedge clk);
        #1 check("flush RdE", 32'(bus.RdE), 0);
        check("flush PCSrcE", 32'(bus.PCSrcE), 0);
        check("flush PCTargetE", bus.PCTargetE, 0);
        check("flush RdM", 32'(bus.RdM), 7);
        bus.FlushE = 1'b0;
        bus.StallE = 1'b0;
        @(posedge clk);
        #1 check("bubble RegWriteM", 32'(bus.RegWriteM), 0);
        check("bubble RdM", 32'(bus.RdM), 0);
        check("bubble ALUResultM", bus.ALUResultM, 0);
        check("after flush RdE", 32'(bus.RdE), 9);
        check("after flush RegWriteM src", 32'(bus.PCSrcE), 0);

        // Async reset between edges with live state in E and M.
        bus.JumpD = 1'b1;
        bus.RdD = 5'd11;
        @(posedge clk);
        #1 check("pre-areset RdM", 32'(bus.RdM), 9);
        check("pre-areset PCSrcE", 32'(bus.PCSrcE), 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_zero("areset");
        #1 reset = 1'b0;
        bus.RdD = 5'd17;
        @(posedge clk);
        #1 check("post-areset RdE", 32'(bus.RdE), 17);
        check("post-areset PCSrcE", 32'(bus.PCSrcE), 1);
        check("post-areset RdM", 32'(bus.RdM), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
